// File: rtl/tetris_pkg.sv
// Shared definitions for the tetromino game-step logic: sequencer states,
// board geometry and the encoding written into board RAM on lock.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_SPAWN,
    ST_IDLE,
    ST_CHECK,
    ST_APPLY,
    ST_LOCK,
    ST_GAME_OVER
  } seq_state_t;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 24;
  localparam int SPAWN_X_DEF = 4;

  // Board cells hold block id + 1 so that zero always means "empty".
  function automatic logic [5:0] lock_data(input logic [2:0] blk);
    return {3'b000, blk} + 6'd1;
  endfunction

endpackage

// File: rtl/piece_sequencer_if.sv
// Handshake between the piece sequencer (master) and the collision checker
// (slave): enable out, per-direction verdicts, completion and the checker's
// own board RAM read address back in.
interface piece_sequencer_if;
  logic       check_enable;
  logic       collides_left;
  logic       collides_right;
  logic       collides_down;
  logic       collides_rotate;
  logic       complete;
  logic [7:0] coll_ram_addr;

  modport master (
    output check_enable,
    input  collides_left, collides_right, collides_down, collides_rotate,
    input  complete, coll_ram_addr
  );

  modport slave (
    input  check_enable,
    output collides_left, collides_right, collides_down, collides_rotate,
    output complete, coll_ram_addr
  );
endinterface

// File: rtl/lut.sv
// Tetromino shape table: for a block id and rotation, returns the four cell
// offsets inside a 4x4 box. Cell k uses coord_x/coord_y bits [2k+1:2k].
// Shapes are stored at rotation 0; each quarter turn maps (x,y) -> (3-y,x).
module lut (
  input  logic [2:0] block,
  input  logic [1:0] curr_rotation,
  output logic [7:0] coord_x,
  output logic [7:0] coord_y
);

  // Nibble k of the result is {y[1:0], x[1:0]} of cell k at rotation 0.
  function automatic logic [15:0] base_cells(input logic [2:0] b);
    case (b)
      3'd0:    return 16'h7654;  // I
      3'd1:    return 16'h6521;  // O
      3'd2:    return 16'h1654;  // T
      3'd3:    return 16'h5421;  // S
      3'd4:    return 16'h6510;  // Z
      3'd5:    return 16'h6540;  // J
      3'd6:    return 16'h6542;  // L
      default: return 16'h5410;  // spare id: 2x2 square in the corner
    endcase
  endfunction

  logic [15:0] w_base;
  assign w_base = base_cells(block);

  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    logic [1:0] w_x;
    logic [1:0] w_y;
    logic [1:0] w_t;

    // Rotate cell gi by the requested number of quarter turns.
    always_comb begin
      w_x = w_base[4*gi +: 2];
      w_y = w_base[4*gi+2 +: 2];
      w_t = 2'd0;
      for (int i = 0; i < 3; i++) begin
        if (i < int'(curr_rotation)) begin
          w_t = w_x;
          w_x = 2'd3 - w_y;
          w_y = w_t;
        end
      end
    end

    assign coord_x[2*gi +: 2] = w_x;
    assign coord_y[2*gi +: 2] = w_y;
  end

endmodule

// File: rtl/piece_sequencer.sv
// Game-step controller for the active tetromino. Latches player/gravity
// requests, runs one collision pass per action, applies at most one move per
// pass, locks blocked pieces into board RAM and spawns the next piece.
// Optional feature macro: PIECE_SEQ_HARD_DROP_EN (adds hard_drop input).
module piece_sequencer
  import tetris_pkg::*;
#(
  parameter int SPAWN_X = SPAWN_X_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              rotate,
  input  logic              drop_tick,
`ifdef PIECE_SEQ_HARD_DROP_EN
  input  logic              hard_drop,
`endif
  input  logic [2:0]        spawn_block,
  output logic              next_req,
  piece_sequencer_if.master coll,
  output logic [4:0]        X_anchor,
  output logic [5:0]        Y_anchor,
  output logic [2:0]        block,
  output logic [1:0]        curr_rotation,
  output logic [7:0]        ram_addr,
  output logic [5:0]        ram_wr_data,
  output logic              ram_wren,
  output logic              lock_done,
  output logic              game_over
);

  seq_state_t r_state, w_state_next;
  logic [4:0] r_x, w_x_next;
  logic [5:0] r_y, w_y_next;
  logic [2:0] r_block, w_block_next;
  logic [1:0] r_rot, w_rot_next;
  logic       r_p_rot, r_p_left, r_p_right, r_p_down;
  logic       w_p_rot_next, w_p_left_next, w_p_right_next, w_p_down_next;
  logic       w_clr_rot, w_clr_left, w_clr_right, w_clr_down;
  logic       r_c_rot, r_c_left, r_c_right, r_c_down;
  logic       w_c_rot_next, w_c_left_next, w_c_right_next, w_c_down_next;
  logic [2:0] r_k, w_k_next;
  logic [5:0] r_wr_data, w_wr_data_next;
  logic       r_next_req;
  logic       w_accept;
`ifdef PIECE_SEQ_HARD_DROP_EN
  logic       r_p_hard, w_p_hard_next, w_clr_hard;
`endif

  // Cell offsets for the lock address of the cell currently being written.
  logic [7:0] w_coord_x, w_coord_y;
  logic [1:0] w_cx, w_cy;
  logic [7:0] w_row, w_lock_addr;

  lut u_lut (
    .block         (r_block),
    .curr_rotation (r_rot),
    .coord_x       (w_coord_x),
    .coord_y       (w_coord_y)
  );

  assign w_cx        = w_coord_x[{r_k[1:0], 1'b0} +: 2];
  assign w_cy        = w_coord_y[{r_k[1:0], 1'b0} +: 2];
  assign w_row       = {2'b00, r_y} + {6'b0, w_cy};
  assign w_lock_addr = w_row * 8'(BOARD_W) + {3'b000, r_x} + {6'b0, w_cx};

  // Requests are accepted everywhere except after the game has ended.
  assign w_accept = (r_state != ST_GAME_OVER);

  // Next-state, piece-state updates and pending-bit bookkeeping.
  always_comb begin
    w_state_next   = r_state;
    w_x_next       = r_x;
    w_y_next       = r_y;
    w_block_next   = r_block;
    w_rot_next     = r_rot;
    w_k_next       = r_k;
    w_wr_data_next = r_wr_data;
    w_c_rot_next   = r_c_rot;
    w_c_left_next  = r_c_left;
    w_c_right_next = r_c_right;
    w_c_down_next  = r_c_down;
    w_clr_rot      = 1'b0;
    w_clr_left     = 1'b0;
    w_clr_right    = 1'b0;
    w_clr_down     = 1'b0;
`ifdef PIECE_SEQ_HARD_DROP_EN
    w_clr_hard     = 1'b0;
`endif

    case (r_state)
      ST_SPAWN: begin
        w_block_next = spawn_block;
        w_x_next     = 5'(SPAWN_X);
        w_y_next     = 6'd0;
        w_rot_next   = 2'd0;
        w_clr_rot    = 1'b1;
        w_clr_left   = 1'b1;
        w_clr_right  = 1'b1;
        w_clr_down   = 1'b1;
`ifdef PIECE_SEQ_HARD_DROP_EN
        w_clr_hard   = 1'b1;
`endif
        w_state_next = ST_IDLE;
      end

      ST_IDLE: begin
        if (r_p_rot || r_p_left || r_p_right || r_p_down
`ifdef PIECE_SEQ_HARD_DROP_EN
            || r_p_hard
`endif
           ) begin
          w_state_next = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (coll.complete) begin
          w_c_rot_next   = coll.collides_rotate;
          w_c_left_next  = coll.collides_left;
          w_c_right_next = coll.collides_right;
          w_c_down_next  = coll.collides_down;
          w_state_next   = ST_APPLY;
        end
      end

      ST_APPLY: begin
        w_state_next = ST_IDLE;
`ifdef PIECE_SEQ_HARD_DROP_EN
        if (r_p_hard) begin
          if (!r_c_down) begin
            w_y_next     = r_y + 6'd1;
            w_state_next = ST_CHECK;
          end else begin
            w_clr_hard     = 1'b1;
            w_k_next       = 3'd0;
            w_wr_data_next = lock_data(r_block);
            w_state_next   = ST_LOCK;
          end
        end else
`endif
        if (r_p_rot) begin
          w_clr_rot = 1'b1;
          if (!r_c_rot) w_rot_next = r_rot + 2'd1;
        end else if (r_p_left) begin
          w_clr_left = 1'b1;
          if (!r_c_left) w_x_next = r_x - 5'd1;
        end else if (r_p_right) begin
          w_clr_right = 1'b1;
          if (!r_c_right) w_x_next = r_x + 5'd1;
        end else if (r_p_down) begin
          if (!r_c_down) begin
            w_y_next   = r_y + 6'd1;
            w_clr_down = 1'b1;
          end else begin
            w_k_next       = 3'd0;
            w_wr_data_next = lock_data(r_block);
            w_state_next   = ST_LOCK;
          end
        end
      end

      ST_LOCK: begin
        // k = 0..3 are the cell writes, k = 4 is the lock_done cycle.
        if (r_k == 3'd4) begin
          w_state_next = (r_y == 6'd0) ? ST_GAME_OVER : ST_SPAWN;
        end else begin
          w_k_next = r_k + 3'd1;
        end
      end

      ST_GAME_OVER: begin
        w_state_next = ST_GAME_OVER;
      end

      default: begin
        w_state_next = ST_SPAWN;
      end
    endcase

    // A new request in the same cycle as its clear keeps the bit set.
    w_p_rot_next   = (r_p_rot   & ~w_clr_rot)   | (rotate     & w_accept);
    w_p_left_next  = (r_p_left  & ~w_clr_left)  | (move_left  & w_accept);
    w_p_right_next = (r_p_right & ~w_clr_right) | (move_right & w_accept);
    w_p_down_next  = (r_p_down  & ~w_clr_down)  | (drop_tick  & w_accept);
`ifdef PIECE_SEQ_HARD_DROP_EN
    w_p_hard_next  = (r_p_hard  & ~w_clr_hard)  | (hard_drop  & w_accept);
`endif
  end

  // State, piece and pending registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_SPAWN;
      r_x        <= 5'(SPAWN_X);
      r_y        <= 6'd0;
      r_block    <= 3'd0;
      r_rot      <= 2'd0;
      r_p_rot    <= 1'b0;
      r_p_left   <= 1'b0;
      r_p_right  <= 1'b0;
      r_p_down   <= 1'b0;
      r_c_rot    <= 1'b0;
      r_c_left   <= 1'b0;
      r_c_right  <= 1'b0;
      r_c_down   <= 1'b0;
      r_k        <= 3'd0;
      r_wr_data  <= 6'd0;
      r_next_req <= 1'b0;
`ifdef PIECE_SEQ_HARD_DROP_EN
      r_p_hard   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_block    <= w_block_next;
      r_rot      <= w_rot_next;
      r_p_rot    <= w_p_rot_next;
      r_p_left   <= w_p_left_next;
      r_p_right  <= w_p_right_next;
      r_p_down   <= w_p_down_next;
      r_c_rot    <= w_c_rot_next;
      r_c_left   <= w_c_left_next;
      r_c_right  <= w_c_right_next;
      r_c_down   <= w_c_down_next;
      r_k        <= w_k_next;
      r_wr_data  <= w_wr_data_next;
      // Pulses alongside the freshly loaded block, one cycle per spawn.
      r_next_req <= (r_state == ST_SPAWN);
`ifdef PIECE_SEQ_HARD_DROP_EN
      r_p_hard   <= w_p_hard_next;
`endif
    end
  end

  assign coll.check_enable = (r_state == ST_CHECK);
  assign X_anchor          = r_x;
  assign Y_anchor          = r_y;
  assign block             = r_block;
  assign curr_rotation     = r_rot;
  assign next_req          = r_next_req;
  assign ram_wren          = (r_state == ST_LOCK) && !r_k[2];
  assign lock_done         = (r_state == ST_LOCK) && r_k[2];
  assign ram_wr_data       = r_wr_data;
  assign game_over         = (r_state == ST_GAME_OVER);
  // The checker owns the RAM address port except while this block is locking.
  assign ram_addr          = (r_state == ST_LOCK) ? w_lock_addr : coll.coll_ram_addr;

endmodule
